// File: rtl/paper_reg_responder_pkg.sv
// Shared SoC constants for the Paper register window: response codes,
// window placement and the byte-strobe expansion helper.
package paper_reg_responder_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  localparam logic [63:0] PAPER_BASE = 64'h1900_0000;
  localparam logic [63:0] PAPER_LEN  = 64'h0000_0C00;

  function automatic logic [63:0] strb_mask(input logic [7:0] strb);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{strb[b]}};
    return m;
  endfunction

endpackage

// File: rtl/paper_addr_decode.sv
// Address decode for the Paper window: in-range flag, register index and
// whether that index maps to an implemented register.
module paper_addr_decode #(
  parameter logic [63:0] BaseAddr = 64'h1900_0000,
  parameter logic [63:0] Length   = 64'hC00,
  parameter int          NumRegs  = 16,
  parameter int          IdxW     = 4
) (
  input  logic [63:0]     addr_i,
  output logic            in_range_o,
  output logic            idx_valid_o,
  output logic [IdxW-1:0] idx_o
);

  logic [63:0] offset;
  logic        unused_bits;

  // Compare the offset against Length rather than forming BaseAddr+Length,
  // so a window touching the top of the address space cannot wrap.
  assign offset      = addr_i - BaseAddr;
  assign in_range_o  = (addr_i >= BaseAddr) && (offset < Length);
  assign idx_valid_o = in_range_o && (offset < (64'(NumRegs) * 64'd8));
  assign idx_o       = offset[IdxW+2:3];
  assign unused_bits = ^{offset[63:IdxW+3], offset[2:0]};

endmodule

// File: rtl/paper_reg_responder.sv
// Paper register responder: independent write (AW/W/B) and read (AR/R) FSMs.
// W: IDLE=take AW/W | HAVE_AW=wait W | HAVE_W=wait AW | RESP=drive B.  R: IDLE=take AR | DATA=drive R.
module paper_reg_responder
  import paper_reg_responder_pkg::*;
#(
  parameter logic [63:0] BaseAddr = PAPER_BASE,
  parameter logic [63:0] Length   = PAPER_LEN,
  parameter int          NumRegs  = 16,
  parameter logic [63:0] IdValue  = 64'h5041_5045_5200_0001
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [63:0]             aw_addr_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  input  logic [63:0]             w_data_i,
  input  logic [7:0]              w_strb_i,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output logic [1:0]              b_resp_o,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [63:0]             ar_addr_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [63:0]             r_data_o,
  output logic [1:0]              r_resp_o,
  output logic [NumRegs*64-1:0]   regs_o,
  output logic [NumRegs-1:0]      wr_pulse_o
);

  localparam int IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;

  logic [63:0]        regs_q [NumRegs];
  logic [63:0]        aw_addr_q, w_data_q, r_data_q, r_data_d;
  logic [7:0]         w_strb_q;
  resp_t              b_resp_q, r_resp_q, w_resp, r_resp_d;
  logic [NumRegs-1:0] wr_pulse_q, wr_pulse_d;

  logic            commit, ld_aw, ld_w, wr_en, r_load;
  logic [63:0]     cmt_addr, cmt_data;
  logic [7:0]      cmt_strb;
  logic            w_in_range, w_idx_valid, r_in_range, r_idx_valid;
  logic [IdxW-1:0] w_idx, r_idx;

  paper_addr_decode #(.BaseAddr(BaseAddr), .Length(Length), .NumRegs(NumRegs), .IdxW(IdxW))
    u_dec_wr (.addr_i(cmt_addr), .in_range_o(w_in_range), .idx_valid_o(w_idx_valid), .idx_o(w_idx));

  paper_addr_decode #(.BaseAddr(BaseAddr), .Length(Length), .NumRegs(NumRegs), .IdxW(IdxW))
    u_dec_rd (.addr_i(ar_addr_i), .in_range_o(r_in_range), .idx_valid_o(r_idx_valid), .idx_o(r_idx));

  always_comb begin
    w_state_d  = w_state_q;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    commit     = 1'b0;
    ld_aw      = 1'b0;
    ld_w       = 1'b0;
    cmt_addr   = aw_addr_q;
    cmt_data   = w_data_q;
    cmt_strb   = w_strb_q;
    case (w_state_q)
      W_IDLE: begin
        aw_ready_o = 1'b1;
        w_ready_o  = 1'b1;
        if (aw_valid_i && w_valid_i) begin
          commit    = 1'b1;
          cmt_addr  = aw_addr_i;
          cmt_data  = w_data_i;
          cmt_strb  = w_strb_i;
          w_state_d = W_RESP;
        end else if (aw_valid_i) begin
          ld_aw     = 1'b1;
          w_state_d = W_HAVE_AW;
        end else if (w_valid_i) begin
          ld_w      = 1'b1;
          w_state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        w_ready_o = 1'b1;
        if (w_valid_i) begin
          commit    = 1'b1;
          cmt_data  = w_data_i;
          cmt_strb  = w_strb_i;
          w_state_d = W_RESP;
        end
      end
      W_HAVE_W: begin
        aw_ready_o = 1'b1;
        if (aw_valid_i) begin
          commit    = 1'b1;
          cmt_addr  = aw_addr_i;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        b_valid_o = 1'b1;
        if (b_ready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    if (!w_in_range)                      w_resp = RESP_DECERR;
    else if (w_idx_valid && w_idx == '0)  w_resp = RESP_SLVERR;
    else                                  w_resp = RESP_OKAY;
    wr_en = commit && w_idx_valid && (w_idx != '0);
    for (int i = 0; i < NumRegs; i++) wr_pulse_d[i] = wr_en && (w_idx == IdxW'(i));
  end

  always_comb begin
    r_state_d  = r_state_q;
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    r_load     = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ar_ready_o = 1'b1;
        if (ar_valid_i) begin
          r_load    = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        r_valid_o = 1'b1;
        if (r_ready_i) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    r_data_d = '0;
    r_resp_d = RESP_OKAY;
    if (!r_in_range)       r_resp_d = RESP_DECERR;
    else if (r_idx_valid)  r_data_d = (r_idx == '0) ? IdValue : regs_q[r_idx];
  end

  // Read data samples regs_q before this edge's write lands: pre-write value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_resp_q   <= RESP_OKAY;
      r_resp_q   <= RESP_OKAY;
      r_data_q   <= '0;
      wr_pulse_q <= '0;
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= (i == 0) ? IdValue : 64'd0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      wr_pulse_q <= wr_pulse_d;
      if (ld_aw) aw_addr_q <= aw_addr_i;
      if (ld_w) begin
        w_data_q <= w_data_i;
        w_strb_q <= w_strb_i;
      end
      if (commit) b_resp_q <= w_resp;
      if (wr_en)
        regs_q[w_idx] <= (regs_q[w_idx] & ~strb_mask(cmt_strb)) | (cmt_data & strb_mask(cmt_strb));
      if (r_load) begin
        r_data_q <= r_data_d;
        r_resp_q <= r_resp_d;
      end
    end
  end

  for (genvar g = 0; g < NumRegs; g++) begin : g_regs
    assign regs_o[64*g +: 64] = regs_q[g];
  end

  assign b_resp_o   = b_resp_q;
  assign r_data_o   = r_data_q;
  assign r_resp_o   = r_resp_q;
  assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_paper_reg_responder.sv
// Directed bench for paper_reg_responder with hand-computed expectations.
module tb_paper_reg_responder;

  localparam logic [63:0] ID = 64'h5041_5045_5200_0001;

  logic          clk = 1'b0;
  logic          rst;
  logic          aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic          ar_valid, ar_ready, r_valid, r_ready;
  logic [63:0]   aw_addr, w_data, ar_addr, r_data;
  logic [7:0]    w_strb;
  logic [1:0]    b_resp, r_resp;
  logic [1023:0] regs;
  logic [15:0]   wr_pulse;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  paper_reg_responder dut (
    .clk_i(clk), .rst_i(rst),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_addr_i(aw_addr),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data), .w_strb_i(w_strb),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_resp_o(b_resp),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_addr_i(ar_addr),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_data_o(r_data), .r_resp_o(r_resp),
    .regs_o(regs), .wr_pulse_o(wr_pulse)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] reg_at(input int i);
    return regs[64*i +: 64];
  endfunction

  task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                          input logic [1:0] er, input logic [15:0] ep);
    aw_valid = 1'b1; aw_addr = a; w_valid = 1'b1; w_data = d; w_strb = s;
    checks++; if (aw_ready !== 1'b1) begin failures++; $error("FAIL wr_aw_ready observed=%0h", aw_ready); end
    step();
    aw_valid = 1'b0; w_valid = 1'b0;
    checks++; if (b_valid !== 1'b1) begin failures++; $error("FAIL wr_b_valid observed=%0h", b_valid); end
    checks++; if (b_resp !== er) begin failures++; $error("FAIL wr_b_resp observed=%0h expected=%0h", b_resp, er); end
    if (s != 8'h00) begin
      checks++; if (wr_pulse !== ep) begin failures++; $error("FAIL wr_pulse observed=%0h expected=%0h", wr_pulse, ep); end
    end
    b_ready = 1'b1;
    step();
    b_ready = 1'b0;
    checks++; if (b_valid !== 1'b0) begin failures++; $error("FAIL wr_b_done observed=%0h", b_valid); end
    checks++; if (wr_pulse !== 16'h0000) begin failures++; $error("FAIL wr_pulse_clear observed=%0h", wr_pulse); end
  endtask

  task automatic do_read(input logic [63:0] a, input logic [63:0] ed, input logic [1:0] er);
    ar_valid = 1'b1; ar_addr = a;
    checks++; if (ar_ready !== 1'b1) begin failures++; $error("FAIL rd_ar_ready observed=%0h", ar_ready); end
    step();
    ar_valid = 1'b0;
    checks++; if (r_valid !== 1'b1) begin failures++; $error("FAIL rd_r_valid observed=%0h", r_valid); end
    checks++; if (r_data !== ed) begin failures++; $error("FAIL rd_r_data observed=%0h expected=%0h", r_data, ed); end
    checks++; if (r_resp !== er) begin failures++; $error("FAIL rd_r_resp observed=%0h expected=%0h", r_resp, er); end
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    checks++; if (r_valid !== 1'b0) begin failures++; $error("FAIL rd_r_done observed=%0h", r_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    aw_valid = 1'b0; aw_addr = '0; w_valid = 1'b0; w_data = '0; w_strb = '0;
    b_ready = 1'b0; ar_valid = 1'b0; ar_addr = '0; r_ready = 1'b0;
    step();
    step();
    checks++; if (b_valid !== 1'b0) begin failures++; $error("FAIL rst_b_valid observed=%0h", b_valid); end
    checks++; if (r_valid !== 1'b0) begin failures++; $error("FAIL rst_r_valid observed=%0h", r_valid); end
    checks++; if (wr_pulse !== 16'h0000) begin failures++; $error("FAIL rst_wr_pulse observed=%0h", wr_pulse); end
    checks++; if (b_resp !== 2'b00) begin failures++; $error("FAIL rst_b_resp observed=%0h", b_resp); end
    checks++; if (r_resp !== 2'b00) begin failures++; $error("FAIL rst_r_resp observed=%0h", r_resp); end
    checks++; if (reg_at(0) !== ID) begin failures++; $error("FAIL rst_reg0 observed=%0h", reg_at(0)); end
    checks++; if (reg_at(1) !== 64'h0) begin failures++; $error("FAIL rst_reg1 observed=%0h", reg_at(1)); end
    rst = 1'b0;
    step();

    // same-cycle AW+W
    do_write(64'h1900_0008, 64'hDEAD_BEEF, 8'hFF, 2'b00, 16'h0002);
    checks++; if (reg_at(1) !== 64'hDEAD_BEEF) begin failures++; $error("FAIL reg1_value observed=%0h", reg_at(1)); end

    // W two cycles ahead of AW with partial strobes
    do_write(64'h1900_0010, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 2'b00, 16'h0004);
    w_valid = 1'b1; w_data = 64'h1122_3344_5566_7788; w_strb = 8'h0F;
    step();
    w_valid = 1'b0;
    checks++; if (aw_ready !== 1'b1) begin failures++; $error("FAIL have_w_aw_ready observed=%0h", aw_ready); end
    checks++; if (w_ready !== 1'b0) begin failures++; $error("FAIL have_w_w_ready observed=%0h", w_ready); end
    step();
    checks++; if (b_valid !== 1'b0) begin failures++; $error("FAIL have_w_no_b observed=%0h", b_valid); end
    aw_valid = 1'b1; aw_addr = 64'h1900_0010;
    step();
    aw_valid = 1'b0;
    checks++; if (b_valid !== 1'b1) begin failures++; $error("FAIL split_b_valid observed=%0h", b_valid); end
    checks++; if (b_resp !== 2'b00) begin failures++; $error("FAIL split_b_resp observed=%0h", b_resp); end
    checks++; if (wr_pulse !== 16'h0004) begin failures++; $error("FAIL split_pulse observed=%0h", wr_pulse); end
    checks++; if (reg_at(2) !== 64'hAAAA_BBBB_5566_7788) begin failures++; $error("FAIL reg2_merge observed=%0h", reg_at(2)); end
    b_ready = 1'b1;
    step();
    b_ready = 1'b0;

    // register 0 is the read-only ID
    do_read(64'h1900_0000, ID, 2'b00);
    do_write(64'h1900_0000, 64'h0, 8'hFF, 2'b10, 16'h0000);
    checks++; if (reg_at(0) !== ID) begin failures++; $error("FAIL reg0_kept observed=%0h", reg_at(0)); end

    // decode boundaries
    do_read(64'h1900_0C00, 64'h0, 2'b11);
    do_write(64'h18FF_FFF8, 64'h1234, 8'hFF, 2'b11, 16'h0000);
    do_read(64'h1900_0BF8, 64'h0, 2'b00);
    do_read(64'h1900_0080, 64'h0, 2'b00);
    do_write(64'h1900_0080, 64'h5555, 8'hFF, 2'b00, 16'h0000);
    do_read(64'h1900_000F, 64'hDEAD_BEEF, 2'b00);
    do_write(64'h1900_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 2'b00, 16'h0000);
    checks++; if (reg_at(1) !== 64'hDEAD_BEEF) begin failures++; $error("FAIL strb0_kept observed=%0h", reg_at(1)); end
    checks++; if (reg_at(2) !== 64'hAAAA_BBBB_5566_7788) begin failures++; $error("FAIL reg2_untouched observed=%0h", reg_at(2)); end

    // B back-pressure while a read completes alongside
    aw_valid = 1'b1; aw_addr = 64'h1900_0018; w_valid = 1'b1; w_data = 64'h0123; w_strb = 8'hFF;
    step();
    aw_valid = 1'b0; w_valid = 1'b0;
    checks++; if (wr_pulse !== 16'h0008) begin failures++; $error("FAIL bp_pulse observed=%0h", wr_pulse); end
    ar_valid = 1'b1; ar_addr = 64'h1900_0008;
    for (int i = 0; i < 5; i++) begin
      checks++; if (b_valid !== 1'b1) begin failures++; $error("FAIL bp_b_valid observed=%0h", b_valid); end
      checks++; if (b_resp !== 2'b00) begin failures++; $error("FAIL bp_b_resp observed=%0h", b_resp); end
      checks++; if (aw_ready !== 1'b0) begin failures++; $error("FAIL bp_aw_ready observed=%0h", aw_ready); end
      checks++; if (w_ready !== 1'b0) begin failures++; $error("FAIL bp_w_ready observed=%0h", w_ready); end
      if (i == 1) begin
        ar_valid = 1'b0;
        checks++; if (r_valid !== 1'b1) begin failures++; $error("FAIL bp_r_valid observed=%0h", r_valid); end
        checks++; if (r_data !== 64'hDEAD_BEEF) begin failures++; $error("FAIL bp_r_data observed=%0h", r_data); end
        r_ready = 1'b1;
      end
      if (i == 2) begin
        checks++; if (r_valid !== 1'b0) begin failures++; $error("FAIL bp_r_done observed=%0h", r_valid); end
        r_ready = 1'b0;
      end
      step();
    end
    b_ready = 1'b1;
    step();
    b_ready = 1'b0;
    checks++; if (b_valid !== 1'b0) begin failures++; $error("FAIL bp_b_done observed=%0h", b_valid); end
    checks++; if (reg_at(3) !== 64'h0123) begin failures++; $error("FAIL reg3_value observed=%0h", reg_at(3)); end

    // read and write of the same register in one cycle: read sees old value
    aw_valid = 1'b1; aw_addr = 64'h1900_0018; w_valid = 1'b1; w_data = 64'h0456; w_strb = 8'hFF;
    ar_valid = 1'b1; ar_addr = 64'h1900_0018;
    step();
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    checks++; if (r_data !== 64'h0123) begin failures++; $error("FAIL rw_r_data_old observed=%0h", r_data); end
    checks++; if (reg_at(3) !== 64'h0456) begin failures++; $error("FAIL rw_reg3_new observed=%0h", reg_at(3)); end
    b_ready = 1'b1; r_ready = 1'b1;
    step();
    b_ready = 1'b0; r_ready = 1'b0;

    // reset while waiting for W
    aw_valid = 1'b1; aw_addr = 64'h1900_0020;
    step();
    aw_valid = 1'b0;
    checks++; if (aw_ready !== 1'b0) begin failures++; $error("FAIL have_aw_aw_ready observed=%0h", aw_ready); end
    checks++; if (w_ready !== 1'b1) begin failures++; $error("FAIL have_aw_w_ready observed=%0h", w_ready); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (aw_ready !== 1'b1) begin failures++; $error("FAIL mid_rst_aw_ready observed=%0h", aw_ready); end
    checks++; if (w_ready !== 1'b1) begin failures++; $error("FAIL mid_rst_w_ready observed=%0h", w_ready); end
    checks++; if (ar_ready !== 1'b1) begin failures++; $error("FAIL mid_rst_ar_ready observed=%0h", ar_ready); end
    checks++; if (b_valid !== 1'b0) begin failures++; $error("FAIL mid_rst_b_valid observed=%0h", b_valid); end
    checks++; if (reg_at(1) !== 64'h0) begin failures++; $error("FAIL mid_rst_reg1 observed=%0h", reg_at(1)); end
    checks++; if (reg_at(0) !== ID) begin failures++; $error("FAIL mid_rst_reg0 observed=%0h", reg_at(0)); end
    step();
    step();
    checks++; if (b_valid !== 1'b0) begin failures++; $error("FAIL mid_rst_no_b observed=%0h", b_valid); end
    checks++; if (r_valid !== 1'b0) begin failures++; $error("FAIL mid_rst_no_r observed=%0h", r_valid); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
